// File: rtl/freq_display_driver.sv
// rtl/freq_display_driver.sv - binary count to BCD (double dabble) and multiplexed 7-segment driver
// Optional leading-zero blanking: define FREQ_DISP_LZB_EN.
module freq_display_driver #(
    parameter int COUNT_W     = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               count_valid,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  digit_sel,
    output logic               busy,
    output logic               overflow
);

    localparam int BCD_W  = (DIGITS + 2) * 4;
    localparam int DISP_W = DIGITS * 4;
    localparam int CNT_W  = $clog2(COUNT_W + 1);
    localparam int RC_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [39:0] MAX_VAL = 40'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t             state, state_nxt;
    logic [COUNT_W-1:0] bin_sr, latched, pend_data, load_val;
    logic [BCD_W-1:0]   bcd_sr, bcd_adj, bcd_nxt;
    logic [COUNT_W-1:0] bin_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic               pend_valid, start_load;
    logic [DISP_W-1:0]  display;
    logic [RC_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [3:0]         cur_nib;
    logic [6:0]         seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        load_val   = count_in;
        case (state)
            S_IDLE: begin
                if (count_valid) begin
                    start_load = 1'b1;
                    state_nxt  = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (bit_cnt == CNT_W'(COUNT_W - 1))
                    state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                // A strobe landing in this cycle is the newest value, so it supersedes the slot.
                if (pend_valid || count_valid) begin
                    start_load = 1'b1;
                    load_val   = count_valid ? count_in : pend_data;
                    state_nxt  = S_CONVERT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS + 2; i++)
            bcd_adj[i*4 +: 4] = (bcd_sr[i*4 +: 4] >= 4'd5) ? bcd_sr[i*4 +: 4] + 4'd3 : bcd_sr[i*4 +: 4];
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin_sr[COUNT_W-1]};
        bin_nxt = {bin_sr[COUNT_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            latched    <= '0;
            bit_cnt    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            display    <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_load) begin
                bin_sr  <= load_val;
                latched <= load_val;
                bcd_sr  <= '0;
                bit_cnt <= '0;
            end else if (state == S_CONVERT) begin
                bin_sr  <= bin_nxt;
                bcd_sr  <= bcd_nxt;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == S_COMMIT) begin
                display  <= bcd_sr[DISP_W-1:0];
                overflow <= 40'(latched) > MAX_VAL;
            end
            if (state == S_COMMIT && start_load)
                pend_valid <= 1'b0;
            else if (count_valid && state != S_IDLE) begin
                pend_data  <= count_in;
                pend_valid <= 1'b1;
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign cur_nib = display[{digit_idx, 2'b00} +: 4];

`ifdef FREQ_DISP_LZB_EN
    logic [DIGITS-1:0] blank;
    logic              zero_above;

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (display[i*4 +: 4] == 4'd0);
            blank[i]   = zero_above && (i != 0);
        end
    end

    always_comb begin
        seg_nxt = decode(cur_nib);
        if (blank[digit_idx])
            seg_nxt = 7'h00;
        if (overflow)
            seg_nxt = 7'h40;
    end
`else
    always_comb begin
        seg_nxt = decode(cur_nib);
        if (overflow)
            seg_nxt = 7'h40;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            digit_sel   <= '0;
            seg         <= '0;
        end else begin
            if (refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            digit_sel <= DIGITS'(1) << digit_idx;
            seg       <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_freq_display_driver.sv
// tb/tb_freq_display_driver.sv - directed self-checking bench for freq_display_driver
module tb_freq_display_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] count_in = '0;
    logic        count_valid = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  digit_sel;
    logic        busy;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef FREQ_DISP_LZB_EN
    localparam logic [6:0] LEAD = 7'h00;
`else
    localparam logic [6:0] LEAD = 7'h3F;
`endif

    freq_display_driver #(.COUNT_W(16), .DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .count_valid(count_valid),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        count_in    = v;
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_digit(input int d, input logic [6:0] exp, input string tag);
        int n = 0;
        @(negedge clk);
        while (digit_sel !== 4'(1 << d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sel"}, 32'(digit_sel), 32'(1 << d));
        chk(tag, 32'(seg), 32'(exp));
    endtask

    initial begin
        int hold;
        int n;
        logic saw6;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_sel", 32'(digit_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_sel", 32'(digit_sel), 32'h1);
        chk("first_seg", 32'(seg), 32'h3F);

        // 1234: exact busy window and scan
        strobe(16'd1234);
        chk("busy_rise", 32'(busy), 32'd1);
        repeat (16) @(negedge clk);
        chk("busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        check_digit(0, 7'h66, "d0_1234");
        check_digit(1, 7'h4F, "d1_1234");
        check_digit(2, 7'h5B, "d2_1234");
        check_digit(3, 7'h06, "d3_1234");

        // Digit hold time: wait for entry into digit 1 from digit 0, then count
        n = 0;
        while (digit_sel !== 4'b0001 && n < 40) begin @(negedge clk); n++; end
        while (digit_sel === 4'b0001 && n < 80) begin @(negedge clk); n++; end
        hold = 0;
        while (digit_sel === 4'b0010 && hold < 40) begin @(negedge clk); hold++; end
        chk("hold_cycles", 32'(hold), 32'd4);

        // Overflow boundary
        strobe(16'd10000);
        wait_idle("idle_10000");
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 32'd1);
        check_digit(0, 7'h40, "d0_10000");
        check_digit(3, 7'h40, "d3_10000");
        strobe(16'd9999);
        wait_idle("idle_9999");
        @(negedge clk);
        chk("ovf_clr", 32'(overflow), 32'd0);
        check_digit(0, 7'h6F, "d0_9999");
        check_digit(1, 7'h6F, "d1_9999");
        check_digit(3, 7'h6F, "d3_9999");

        // Back-to-back 5,6,7: 7 replaces 6 in the pending slot
        @(negedge clk);
        count_in = 16'd5; count_valid = 1'b1;
        @(negedge clk);
        count_in = 16'd6;
        @(negedge clk);
        count_in = 16'd7;
        @(negedge clk);
        count_valid = 1'b0;
        saw6 = 1'b0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (digit_sel === 4'b0001 && seg === 7'h7D) saw6 = 1'b1;
        end
        chk("b2b_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_busy_fall", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digit_sel === 4'b0001 && seg === 7'h7D) saw6 = 1'b1;
        end
        chk("b2b_no6", 32'(saw6), 32'd0);
        check_digit(0, 7'h07, "d0_7");
        check_digit(1, LEAD, "d1_7");
        check_digit(2, LEAD, "d2_7");
        check_digit(3, LEAD, "d3_7");

        // Mid-conversion reset
        strobe(16'd4321);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'd0);
        chk("mid_rst_sel", 32'(digit_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_digit(0, 7'h3F, "d0_after_rst");
        check_digit(1, LEAD, "d1_after_rst");
        strobe(16'd4321);
        wait_idle("idle_4321");
        check_digit(0, 7'h06, "d0_4321");
        check_digit(1, 7'h5B, "d1_4321");
        check_digit(2, 7'h4F, "d2_4321");
        check_digit(3, 7'h66, "d3_4321");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
